// File: rtl/mc_ctrl_unit.sv
// mc_ctrl_unit: multicycle MIPS control FSM with memory handshake,
// precise exceptions and masked interrupts. Option: MC_CTRL_SYSCALL_EN.
module mc_ctrl_unit #(
  parameter int IRQ_N  = 6,
  parameter int MEM_TO = 15,
  parameter int TO_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic [4:0]       rs,
  input  logic             zero,
  input  logic             overflow,
  input  logic             mem_rdy,
  input  logic [IRQ_N-1:0] irq,
  input  logic [IRQ_N-1:0] im,
  input  logic             exl,
  output logic             pcwr,
  output logic             irwr,
  output logic             regwr,
  output logic             memwr,
  output logic             memrd,
  output logic             cp0we,
  output logic             exlset,
  output logic             exlclr,
  output logic             alusrc,
  output logic             extop,
  output logic             luisel,
  output logic             lb,
  output logic             sb,
  output logic [1:0]       regdst,
  output logic [2:0]       memtoreg,
  output logic [2:0]       npcsel,
  output logic [2:0]       aluctr,
  output logic [4:0]       exccode
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXE, S_WB, S_BRANCH, S_JUMP, S_INTR
  } state_t;

  localparam logic [4:0] EC_INT = 5'd0;
  localparam logic [4:0] EC_IBE = 5'd6;
  localparam logic [4:0] EC_DBE = 5'd7;
  localparam logic [4:0] EC_RI  = 5'd10;
  localparam logic [4:0] EC_OV  = 5'd12;
`ifdef MC_CTRL_SYSCALL_EN
  localparam logic [4:0] EC_SYS = 5'd8;
  localparam logic [4:0] EC_BP  = 5'd9;
`endif

  localparam logic [TO_W-1:0] TO_LAST =
    TO_W'(MEM_TO > 0 ? MEM_TO - 1 : 0);

  state_t state, state_n;
  logic [TO_W-1:0] cnt;
  logic [4:0] cause;

  logic rtype, cop0;
  logic i_addu, i_subu, i_add, i_sub, i_and, i_or, i_slt, i_jr;
  logic i_ori, i_lui, i_addiu, i_addi;
  logic i_lw, i_lb, i_sw, i_sb, i_beq, i_bne, i_j, i_jal;
  logic i_eret, i_mtc0, i_mfc0;
  logic r_alu, imm_alu, ld, st, is_br, is_jmp, is_cp0, ov_op;
  logic irq_pend, to_hit;
  state_t end_n;

  assign rtype   = op == 6'b000000;
  assign cop0    = op == 6'b010000;
  assign i_add   = rtype & (func == 6'b100000);
  assign i_addu  = rtype & (func == 6'b100001);
  assign i_sub   = rtype & (func == 6'b100010);
  assign i_subu  = rtype & (func == 6'b100011);
  assign i_and   = rtype & (func == 6'b100100);
  assign i_or    = rtype & (func == 6'b100101);
  assign i_slt   = rtype & (func == 6'b101010);
  assign i_jr    = rtype & (func == 6'b001000);
  assign i_j     = op == 6'b000010;
  assign i_jal   = op == 6'b000011;
  assign i_beq   = op == 6'b000100;
  assign i_bne   = op == 6'b000101;
  assign i_addi  = op == 6'b001000;
  assign i_addiu = op == 6'b001001;
  assign i_ori   = op == 6'b001101;
  assign i_lui   = op == 6'b001111;
  assign i_lb    = op == 6'b100000;
  assign i_lw    = op == 6'b100011;
  assign i_sb    = op == 6'b101000;
  assign i_sw    = op == 6'b101011;
  assign i_mfc0  = cop0 & (rs == 5'b00000);
  assign i_mtc0  = cop0 & (rs == 5'b00100);
  assign i_eret  = cop0 & (rs == 5'b10000) & (func == 6'b011000);

  assign r_alu   = i_addu | i_subu | i_add | i_sub
                 | i_and | i_or | i_slt;
  assign imm_alu = i_ori | i_lui | i_addiu | i_addi;
  assign ld      = i_lw | i_lb;
  assign st      = i_sw | i_sb;
  assign is_br   = i_beq | i_bne;
  assign is_jmp  = i_j | i_jal | i_jr | i_eret;
  assign is_cp0  = i_mtc0 | i_mfc0;
  assign ov_op   = i_add | i_sub | i_addi;

  assign irq_pend = (|(irq & im)) & ~exl;
  assign to_hit   = (MEM_TO != 0) && !mem_rdy && (cnt == TO_LAST);
  assign end_n    = irq_pend ? S_INTR : S_FETCH;

  assign extop  = ld | st | i_addi | is_br;
  assign alusrc = imm_alu | ld | st;
  assign luisel = i_lui;
  assign lb     = i_lb;
  assign sb     = i_sb;
  assign regdst = i_jal ? 2'd2 : (rtype ? 2'd1 : 2'd0);

  // write-back source and ALU op follow the instruction, not the state
  always_comb begin
    memtoreg = 3'd0;
    aluctr   = 3'd0;
    unique case (1'b1)
      ld:     memtoreg = 3'd1;
      i_jal:  memtoreg = 3'd2;
      i_mfc0: memtoreg = 3'd4;
      default: ;
    endcase
    unique case (1'b1)
      i_subu | i_sub | is_br: aluctr = 3'd1;
      i_or | i_ori:           aluctr = 3'd2;
      i_slt:                  aluctr = 3'd3;
      i_and:                  aluctr = 3'd4;
      i_lui:                  aluctr = 3'd5;
      default: ;
    endcase
  end

  // state, wait counter and latched exception cause
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_FETCH;
      cnt     <= '0;
      exccode <= '0;
    end else begin
      state <= state_n;
      if (state_n != state || mem_rdy) cnt <= '0;
      else cnt <= cnt + 1'b1;
      if (state_n == S_INTR) exccode <= cause;
    end
  end

  // next state; synchronous faults take priority over interrupts
  always_comb begin
    state_n = state;
    cause   = EC_INT;
    unique case (state)
      S_FETCH:
        if (mem_rdy) state_n = S_DECODE;
        else if (to_hit) begin
          state_n = S_INTR;
          cause   = EC_IBE;
        end
      S_DECODE: begin
        unique case (1'b1)
          ld | st:          state_n = S_MEMADR;
          r_alu | imm_alu:  state_n = S_EXE;
          is_br:            state_n = S_BRANCH;
          is_jmp:           state_n = S_JUMP;
          is_cp0:           state_n = S_WB;
`ifdef MC_CTRL_SYSCALL_EN
          rtype & (func == 6'b001100): begin
            state_n = S_INTR;
            cause   = EC_SYS;
          end
          rtype & (func == 6'b001101): begin
            state_n = S_INTR;
            cause   = EC_BP;
          end
`endif
          default: begin
            state_n = S_INTR;
            cause   = EC_RI;
          end
        endcase
      end
      S_MEMADR: state_n = ld ? S_MEMRD : S_MEMWR;
      S_MEMRD:
        if (mem_rdy) state_n = S_MEMWB;
        else if (to_hit) begin
          state_n = S_INTR;
          cause   = EC_DBE;
        end
      S_MEMWR:
        if (mem_rdy) state_n = end_n;
        else if (to_hit) begin
          state_n = S_INTR;
          cause   = EC_DBE;
        end
      S_EXE:
        if (ov_op & overflow) begin
          state_n = S_INTR;
          cause   = EC_OV;
        end else state_n = S_WB;
      S_MEMWB, S_WB, S_BRANCH, S_JUMP: state_n = end_n;
      S_INTR:  state_n = S_FETCH;
      default: state_n = S_FETCH;
    endcase
  end

  // per-state strobes, all write strobes held off during reset
  always_comb begin
    pcwr   = 1'b0;
    irwr   = 1'b0;
    regwr  = 1'b0;
    memwr  = 1'b0;
    memrd  = 1'b0;
    cp0we  = 1'b0;
    exlset = 1'b0;
    exlclr = 1'b0;
    npcsel = 3'd0;
    unique case (state)
      S_FETCH: begin
        memrd = 1'b1;
        pcwr  = mem_rdy;
        irwr  = mem_rdy;
      end
      S_MEMRD: memrd = 1'b1;
      S_MEMWR: memwr = 1'b1;
      S_MEMWB: regwr = 1'b1;
      S_WB: begin
        regwr = ~i_mtc0;
        cp0we = i_mtc0;
      end
      S_BRANCH: begin
        npcsel = 3'd1;
        pcwr   = (i_beq & zero) | (i_bne & ~zero);
      end
      S_JUMP: begin
        pcwr   = 1'b1;
        regwr  = i_jal;
        exlclr = i_eret;
        npcsel = i_eret ? 3'd4 : (i_jr ? 3'd3 : 3'd2);
      end
      S_INTR: begin
        pcwr   = 1'b1;
        npcsel = 3'd5;
        cp0we  = 1'b1;
        exlset = 1'b1;
      end
      default: ;
    endcase
    if (!reset) begin
      pcwr   = 1'b0;
      irwr   = 1'b0;
      regwr  = 1'b0;
      memwr  = 1'b0;
      cp0we  = 1'b0;
      exlset = 1'b0;
      exlclr = 1'b0;
    end
  end

endmodule

// File: doc/mc_ctrl_unit.md
Name: mc_ctrl_unit

Overview:
- Multicycle MIPS control FSM; next generation of the `cu` block.
- Drives datapath strobes and mux selects for PC, IR, GPR file, data memory, ALU and CP0.
- New over `cu`: memory ready handshake with timeout, parametrised interrupt vector with mask, precise exceptions (RI, Ov, bus error) reported through an exception code, extended ISA (and, or, add, sub, bne).

Parameters:
- IRQ_N, 6, number of hardware interrupt lines.
- MEM_TO, 15, max wait cycles for mem_rdy before bus error; 0 = wait forever.
- TO_W, 4, width of the timeout counter; must satisfy 2^TO_W > MEM_TO.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- op  in  6  IR[31:26].
- func  in  6  IR[5:0].
- rs  in  5  IR[25:21].
- zero  in  1  ALU zero flag.
- overflow  in  1  ALU signed overflow.
- mem_rdy  in  1  memory completes the current request this cycle.
- irq  in  IRQ_N  level interrupt requests.
- im  in  IRQ_N  interrupt mask from CP0 SR.
- exl  in  1  CP0 EXL bit; 1 blocks interrupts.
- pcwr, irwr, regwr, memwr, memrd, cp0we, exlset, exlclr  out  1  strobes/requests.
- alusrc, extop, luisel, lb, sb  out  1  datapath selects.
- regdst  out  2  write-register select: 0 rt, 1 rd, 2 $31.
- memtoreg  out  3  write-back source: 0 ALU, 1 mem, 2 PC, 4 CP0.
- npcsel  out  3  next PC: 0 PC+4, 1 branch, 2 j/jal target, 3 jr, 4 EPC, 5 exception vector.
- aluctr  out  3  ALU op: 0 add, 1 sub, 2 or, 3 slt, 4 and, 5 lui.
- exccode  out  5  registered cause: 0 Int, 6 IBE, 7 DBE, 10 RI, 12 Ov.

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXE, WB, BRANCH, JUMP, INTR.
- Reset (reset=0):
  - state=FETCH, timeout counter=0, exccode=0.
  - pcwr, irwr, regwr, memwr, cp0we, exlset, exlclr forced 0 while reset low.
- FETCH:
  - memrd=1; pcwr=irwr=1 only in the cycle mem_rdy=1, then go to DECODE.
  - Else stay and count; counter reaching MEM_TO -> INTR with exccode 6.
- DECODE:
  - lw/sw/lb/sb -> MEMADR.
  - R-ALU/ori/lui/addiu/addi -> EXE.
  - beq/bne -> BRANCH.
  - j/jal/jr/eret -> JUMP.
  - mtc0/mfc0 -> WB.
  - Any undefined encoding -> INTR with exccode 10.
- MEMADR: lw/lb -> MEMRD; sw/sb -> MEMWR.
- MEMRD: memrd=1 until mem_rdy, then MEMWB. Timeout -> INTR with exccode 7; no register write.
- MEMWR: memwr=1 level until mem_rdy (the write completes then). Timeout -> INTR with exccode 7.
- MEMWB: regwr=1, memtoreg=1, regdst=0.
- EXE: if add/sub/addi and overflow=1 -> INTR with exccode 12; regwr never asserted for that instruction. Else -> WB.
- WB: regwr=1, except mtc0, which asserts cp0we=1 instead.
- BRANCH: pcwr = (beq&zero)|(bne&~zero); npcsel=1; aluctr=1.
- JUMP:
  - pcwr=1.
  - jal: regwr=1, regdst=2, memtoreg=2.
  - eret: npcsel=4, exlclr=1.
- Instruction end states are MEMWB, MEMWR (on mem_rdy), WB, BRANCH and JUMP. Each exits to INTR if |(irq&im)| & ~exl, else to FETCH.
- Synchronous exception beats interrupt when both are present in the same cycle.
- INTR (1 cycle):
  - pcwr=1, npcsel=5, cp0we=1, exlset=1.
  - exccode register loads the cause on entry to INTR.
  - Next state is FETCH.
- Timeout counter clears on every state change and on mem_rdy.
- npcsel=0 outside BRANCH, JUMP and INTR.
- Combinational selects:
  - extop = lw|lb|sw|sb|addi|beq|bne.
  - alusrc = I-type ALU ops and memory ops.
  - luisel = lui.
  - lb, sb: opcode decode.
- Minimum latencies (mem_rdy=1 immediately):
  - lw: 5 cycles; sw: 4; R-type/imm: 4.
  - branch/jump: 3; mtc0/mfc0: 3.
  - +1 cycle when INTR is taken.

Optional Feature:
- Macro MC_CTRL_SYSCALL_EN.
- When defined: syscall (op 0, func 001100) and break (func 001101) decode in DECODE and go to INTR with exccode 8 or 9 respectively.
- When undefined: both encodings raise RI (exccode 10).

Test Plan:
- addu with mem_rdy held high -> FETCH, DECODE, EXE, WB (4 cycles); regwr=1 only in WB, regdst=1, memtoreg=0.
- lw with mem_rdy low 3 cycles in MEMRD -> memrd held 3+1 cycles; regwr pulses once in MEMWB; total 8 cycles.
- sw with mem_rdy never high and MEM_TO=15 -> memwr high 15 cycles, then INTR with exccode=7, pcwr=1, npcsel=5, no regwr.
- addi with overflow=1 -> EXE to INTR, exccode=12, regwr stays 0 for the whole instruction.
- irq=6'b000100, im=6'b000100, exl=0 during beq (zero=1) -> BRANCH with pcwr=1, then INTR with exccode=0. Repeat with exl=1 -> returns to FETCH.
- op=6'b111111 -> DECODE to INTR with exccode=10. Assert reset=0 mid-MEMWR -> state FETCH, memwr=0 immediately.
